tm1638_key_events: RTL and testbench

TM1638_KEY_EVENTS -- requirements
Module: tm1638_key_events

---
 rtl/tm1638_pkg.sv | 12 +
 rtl/tm1638_evt_fifo.sv | 38 +++
 rtl/tm1638_key_events.sv | 72 +++++++
 tb/tb_tm1638_key_events.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared constants and event record for the TM1638 key-event path.
package tm1638_pkg;
    localparam int NUM_KEYS = 8;
    localparam int KEY_W = 3;
    localparam int EVT_W = 4;
    localparam int DEF_DEBOUNCE_SCANS = 3;
    localparam int DEF_FIFO_DEPTH = 4;
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             press;
    } evt_t;
endpackage

// File: rtl/tm1638_evt_fifo.sv
// tm1638_evt_fifo: first-word-fall-through event FIFO with occupancy count.
module tm1638_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign valid = count != '0;
    assign do_push = push && count != (AW+1)'(DEPTH);
    assign do_pop = pop && valid;
    assign dout = mem[rd_ptr];
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/tm1638_key_events.sv
// tm1638_key_events: per-key scan debounce, press/release encoding and event queueing.
module tm1638_key_events
    import tm1638_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                scan_valid,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic                evt_press,
    output logic                overflow,
    input  logic                clear_ovf
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    logic [CW-1:0] cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] pending, dir, accept, pushed;
    logic [KEY_W-1:0] sel;
    logic [FW-1:0] count;
    logic push, ovf_evt;
    evt_t din, dout;
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            accept[i] = scan_valid && keys_raw[i] != keys_stable[i] && cnt[i] == CW'(DEBOUNCE_SCANS - 1);
    end
    // Downward scan leaves the lowest-index pending key selected.
    always_comb begin
        sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (pending[i]) sel = KEY_W'(i);
    end
    assign push = |pending && count != FW'(FIFO_DEPTH);
    assign pushed = push ? {{(NUM_KEYS-1){1'b0}}, 1'b1} << sel : '0;
    assign ovf_evt = |(accept & pending & ~pushed);
    assign din = '{key: sel, press: dir[sel]};
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
            keys_stable <= '0;
            pending <= '0;
            dir <= '0;
            overflow <= 1'b0;
        end else begin
            if (scan_valid)
                for (int i = 0; i < NUM_KEYS; i++)
                    cnt[i] <= (keys_raw[i] == keys_stable[i] || accept[i]) ? '0 : cnt[i] + 1'b1;
            keys_stable <= keys_stable ^ accept;
            pending <= (pending & ~pushed) | accept;
            dir <= (dir & ~accept) | (keys_raw & accept);
            overflow <= ovf_evt || (overflow && !clear_ovf);
        end
    end
    tm1638_evt_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .n_rst(n_rst),
        .push(push),
        .din(din),
        .pop(evt_ready),
        .dout(dout),
        .valid(evt_valid),
        .count(count)
    );
    assign evt_key = dout.key;
    assign evt_press = dout.press;
endmodule

// File: tb/tb_tm1638_key_events.sv
// tb_tm1638_key_events: vector table, directed corner sequences and random run against a queue model.
module tb_tm1638_key_events;
    localparam int DEB = 3;
    localparam int DEPTH = 4;
    logic clk = 0, n_rst = 1, scan_valid = 0, evt_ready = 0, clear_ovf = 0;
    logic [7:0] keys_raw = '0, keys_stable;
    logic evt_valid, evt_press, overflow;
    logic [2:0] evt_key;
    int checks = 0, errors = 0;

    tm1638_key_events #(.DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .scan_valid(scan_valid), .keys_raw(keys_raw),
        .keys_stable(keys_stable), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_key(evt_key), .evt_press(evt_press), .overflow(overflow), .clear_ovf(clear_ovf)
    );
    always #5 clk = ~clk;

    // Model: a key is accepted after DEB consecutive differing scans; events queue in order.
    logic [7:0] m_stable, m_pend, m_dir;
    int m_run [8];
    logic [3:0] m_q [$];
    bit m_ovf;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = '0; m_pend = '0; m_dir = '0; m_ovf = 0;
        foreach (m_run[i]) m_run[i] = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        int pi;
        bit ovf_new;
        bit do_pop;
        do_pop = evt_ready && m_q.size() > 0;
        pi = -1;
        if (m_q.size() < DEPTH)
            for (int i = 0; i < 8; i++) if (m_pend[i] && pi < 0) pi = i;
        if (do_pop) void'(m_q.pop_front());
        if (pi >= 0) begin
            m_q.push_back({3'(pi), m_dir[pi]});
            m_pend[pi] = 0;
        end
        ovf_new = 0;
        if (scan_valid)
            for (int i = 0; i < 8; i++) begin
                if (keys_raw[i] == m_stable[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = ~m_stable[i];
                        m_run[i] = 0;
                        if (m_pend[i]) ovf_new = 1;
                        m_pend[i] = 1;
                        m_dir[i] = m_stable[i];
                    end
                end
            end
        if (ovf_new) m_ovf = 1;
        else if (clear_ovf) m_ovf = 0;
    endtask

    task automatic compare_model();
        check("model_stable", keys_stable, m_stable);
        check("model_valid", 8'(evt_valid), 8'(m_q.size() != 0));
        if (m_q.size() != 0) check("model_event", 8'({evt_key, evt_press}), 8'(m_q[0]));
        check("model_overflow", 8'(overflow), 8'(m_ovf));
    endtask

    task automatic cycle();
        if (n_rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic scan(logic [7:0] raw, int n);
        repeat (n) begin
            scan_valid = 1; keys_raw = raw; cycle();
            scan_valid = 0; cycle();
        end
    endtask

    task automatic do_reset();
        n_rst = 1; scan_valid = 0; evt_ready = 0; clear_ovf = 0;
        cycle(); cycle();
        n_rst = 0;
    endtask

    typedef struct {
        bit scan; logic [7:0] raw; bit ready;
        logic [7:0] e_stable; bit e_valid; logic [2:0] e_key; bit e_press;
    } vec_t;
    vec_t tbl [14];
    logic [3:0] got [$];

    initial begin
        tbl[0]  = '{1, 8'h04, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 8'h04, 0, 8'h00, 0, 0, 0};
        tbl[2]  = '{1, 8'h04, 0, 8'h04, 0, 0, 0};
        tbl[3]  = '{0, 8'h04, 0, 8'h04, 1, 2, 1};
        tbl[4]  = '{0, 8'h04, 1, 8'h04, 0, 0, 0};
        tbl[5]  = '{1, 8'h14, 0, 8'h04, 0, 0, 0};
        tbl[6]  = '{1, 8'h14, 0, 8'h04, 0, 0, 0};
        tbl[7]  = '{1, 8'h04, 0, 8'h04, 0, 0, 0};
        tbl[8]  = '{1, 8'h14, 0, 8'h04, 0, 0, 0};
        tbl[9]  = '{1, 8'h14, 0, 8'h04, 0, 0, 0};
        tbl[10] = '{0, 8'h14, 0, 8'h04, 0, 0, 0};
        tbl[11] = '{1, 8'h14, 0, 8'h14, 0, 0, 0};
        tbl[12] = '{0, 8'h14, 1, 8'h14, 1, 4, 1};
        tbl[13] = '{0, 8'h14, 1, 8'h14, 0, 0, 0};

        do_reset();
        check("reset_stable", keys_stable, 8'h00);
        check("reset_valid", 8'(evt_valid), 8'h00);
        check("reset_overflow", 8'(overflow), 8'h00);
        foreach (tbl[v]) begin
            scan_valid = tbl[v].scan; keys_raw = tbl[v].raw; evt_ready = tbl[v].ready;
            cycle();
            check($sformatf("vec%0d_stable", v), keys_stable, tbl[v].e_stable);
            check($sformatf("vec%0d_valid", v), 8'(evt_valid), 8'(tbl[v].e_valid));
            if (tbl[v].e_valid) check($sformatf("vec%0d_event", v), 8'({evt_key, evt_press}), 8'({tbl[v].e_key, tbl[v].e_press}));
        end
        scan_valid = 0; evt_ready = 0;

        // Two simultaneous presses come out lowest key first, back to back.
        do_reset();
        evt_ready = 1;
        scan(8'h81, 2);
        scan_valid = 1; cycle(); scan_valid = 0;
        check("dual_stable", keys_stable, 8'h81);
        cycle();
        check("dual_first", 8'({evt_valid, evt_key, evt_press}), 8'b1_000_1);
        cycle();
        check("dual_second", 8'({evt_valid, evt_key, evt_press}), 8'b1_111_1);
        cycle();
        check("dual_empty", 8'(evt_valid), 8'h00);

        // Five changes into a four-deep FIFO: the fifth waits without overflow.
        do_reset();
        scan(8'h1F, 3);
        repeat (5) cycle();
        check("full_head", 8'({evt_valid, evt_key, evt_press}), 8'b1_000_1);
        check("full_ovf", 8'(overflow), 8'h00);
        got.delete();
        evt_ready = 1;
        repeat (12) begin
            if (evt_valid) got.push_back({evt_key, evt_press});
            cycle();
        end
        evt_ready = 0;
        check("full_count", 8'(got.size()), 8'd5);
        foreach (got[i]) check($sformatf("full_evt%0d", i), 8'(got[i]), 8'({3'(i), 1'b1}));

        // Press then release key 3 while its event is stuck behind a full FIFO.
        do_reset();
        scan(8'h17, 3);
        repeat (5) cycle();
        scan(8'h1F, 3);
        check("lost_ovf_before", 8'(overflow), 8'h00);
        scan(8'h17, 2);
        scan_valid = 1; clear_ovf = 1; cycle();
        check("lost_ovf_clear_same_cycle", 8'(overflow), 8'h01);
        scan_valid = 0; clear_ovf = 0; cycle();
        got.delete();
        evt_ready = 1;
        repeat (12) begin
            if (evt_valid) got.push_back({evt_key, evt_press});
            cycle();
        end
        evt_ready = 0;
        check("lost_count", 8'(got.size()), 8'd5);
        if (got.size() == 5) begin
            check("lost_e0", 8'(got[0]), 8'b0001);
            check("lost_e1", 8'(got[1]), 8'b0011);
            check("lost_e2", 8'(got[2]), 8'b0101);
            check("lost_e3", 8'(got[3]), 8'b1001);
            check("lost_e4", 8'(got[4]), 8'b0110);
        end
        check("lost_ovf_held", 8'(overflow), 8'h01);
        clear_ovf = 1; cycle(); clear_ovf = 0;
        check("lost_ovf_cleared", 8'(overflow), 8'h00);

        // Reset with queued events and all keys held.
        do_reset();
        scan(8'h07, 3);
        repeat (3) cycle();
        check("rst_queued", 8'(evt_valid), 8'h01);
        keys_raw = 8'hFF;
        #2 n_rst = 1;
        model_reset();
        #1;
        check("rst_async_valid", 8'(evt_valid), 8'h00);
        check("rst_async_stable", keys_stable, 8'h00);
        cycle(); cycle();
        n_rst = 0;
        scan(8'hFF, 2);
        check("rst_held_stable", keys_stable, 8'h00);
        check("rst_held_valid", 8'(evt_valid), 8'h00);
        scan_valid = 1; cycle(); scan_valid = 0;
        check("rst_redebounced", keys_stable, 8'hFF);
        cycle();
        check("rst_first_evt", 8'({evt_valid, evt_key, evt_press}), 8'b1_000_1);

        // Random bouncing keys, sparse consumer, occasional clears and resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            scan_valid = $urandom_range(0, 2) == 0;
            if (scan_valid) keys_raw = keys_raw ^ 8'($urandom & $urandom & $urandom);
            evt_ready = $urandom_range(0, 3) == 0;
            clear_ovf = $urandom_range(0, 19) == 0;
            n_rst = $urandom_range(0, 599) == 0;
            cycle();
        end
        n_rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
